pulse_period_checker: RTL and testbench

//  Downstream monitor for a periodic delay/tick generator. Measures the cycle count between

---
 rtl/ppc_pkg.sv | 17 +
 rtl/ppc_interval_counter.sv | 50 +++++
 rtl/pulse_period_checker.sv | 141 ++++++++++++++
 tb/tb_pulse_period_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ppc_pkg.sv
// Shared types and constants for the pulse period checker.
package ppc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } ppc_state_t;

    localparam int MISS_W = 8;

    function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ppc_interval_counter.sv
// Saturating interval counter between tick pulses, with decode of the
// measured interval against the tolerance window.
module ppc_interval_counter
    import ppc_pkg::*;
#(
    parameter int PERIOD = 22501,
    parameter int TOL    = 2,
    parameter int CBITS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    output logic [CBITS-1:0] m,
    output logic             good,
    output logic             early_hit,
    output logic             late_hit
);

    localparam logic [CBITS-1:0] LO_LIM   = CBITS'(PERIOD - TOL);
    localparam logic [CBITS-1:0] HI_LIM   = CBITS'(PERIOD + TOL);
    localparam logic [CBITS-1:0] LATE_LIM = CBITS'(PERIOD + TOL + 1);

    logic [CBITS-1:0] icnt_q, icnt_d;

    always_comb begin
        icnt_d = (&icnt_q) ? icnt_q : icnt_q + 1'b1;
        if (clr || tick) begin
            icnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
        end
    end

    // m saturates with icnt so a stalled counter never wraps into the early range.
    assign m = (&icnt_q) ? icnt_q : icnt_q + 1'b1;

    assign good      = tick && (m >= LO_LIM) && (m <= HI_LIM);
    assign early_hit = tick && (m < LO_LIM);
    // Covers both the timeout (no tick) and a tick landing exactly on the limit;
    // fires at most once per interval because m passes this value only once.
    assign late_hit  = (m == LATE_LIM);

endmodule

// File: rtl/pulse_period_checker.sv
// Tick period monitor: lock acquisition and early/late fault detection.
// Optional feature macro: PPC_AUTO_RECOVER_EN (FAULT recovers after good ticks).
//
// state  | meaning
// IDLE   | waiting for the reference tick, no comparisons
// ACQ    | counting consecutive good periods toward lock
// LOCKED | periods within tolerance
// FAULT  | early/late seen while locked
module pulse_period_checker
    import ppc_pkg::*;
#(
    parameter int PERIOD   = 22501,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4,
    parameter int CBITS    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clr,
    output logic              locked,
    output logic              fault,
    output logic              early,
    output logic              late,
    output logic [CBITS-1:0]  period,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LAST_RUN = GW'(LOCK_CNT - 1);

    logic [CBITS-1:0] m;
    logic             good, early_hit, late_hit;

    ppc_interval_counter #(
        .PERIOD (PERIOD),
        .TOL    (TOL),
        .CBITS  (CBITS)
    ) u_icnt (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .clr       (clr),
        .m         (m),
        .good      (good),
        .early_hit (early_hit),
        .late_hit  (late_hit)
    );

    ppc_state_t        state_q, state_d;
    logic [GW-1:0]     goodrun_q, goodrun_d;
    logic              early_q, early_d;
    logic              late_q, late_d;
    logic [CBITS-1:0]  period_q, period_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              active;

    // A clr cycle is treated as if every other input were absent.
    assign active = (state_q != IDLE) && !clr;

    always_comb begin
        state_d   = state_q;
        goodrun_d = goodrun_q;
        early_d   = active && early_hit;
        late_d    = active && late_hit;
        period_d  = (active && tick) ? m : period_q;
        miss_d    = (early_d || late_d) ? sat_inc_miss(miss_q) : miss_q;

        if (clr) begin
            state_d   = IDLE;
            goodrun_d = '0;
            miss_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_d   = ACQ;
                        goodrun_d = '0;
                    end
                end
                ACQ: begin
                    if (good) begin
                        goodrun_d = goodrun_q + 1'b1;
                        if (goodrun_q == LAST_RUN) begin
                            state_d = LOCKED;
                        end
                    end else if (tick || late_hit) begin
                        goodrun_d = '0;
                    end
                end
                LOCKED: begin
                    if (early_hit || late_hit) begin
                        state_d   = FAULT;
                        goodrun_d = '0;
                    end
                end
                FAULT: begin
`ifdef PPC_AUTO_RECOVER_EN
                    if (good) begin
                        goodrun_d = goodrun_q + 1'b1;
                        if (goodrun_q == LAST_RUN) begin
                            state_d = LOCKED;
                        end
                    end else if (tick || late_hit) begin
                        goodrun_d = '0;
                    end
`else
                    state_d = FAULT;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            goodrun_q <= '0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
            period_q  <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            goodrun_q <= goodrun_d;
            early_q   <= early_d;
            late_q    <= late_d;
            period_q  <= period_d;
            miss_q    <= miss_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign fault    = (state_q == FAULT);
    assign early    = early_q;
    assign late     = late_q;
    assign period   = period_q;
    assign miss_cnt = miss_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker with PERIOD=20, TOL=2, LOCK_CNT=4.
module tb_pulse_period_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        clr = 1'b0;
    logic        locked, fault, early, late;
    logic [15:0] period;
    logic [7:0]  miss_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int early_n  = 0;
    int late_n   = 0;

    pulse_period_checker #(
        .PERIOD   (20),
        .TOL      (2),
        .LOCK_CNT (4),
        .CBITS    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .clr      (clr),
        .locked   (locked),
        .fault    (fault),
        .early    (early),
        .late     (late),
        .period   (period),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at a falling edge, sample outputs at the next one.
    task automatic step(input logic t, input logic c);
        tick = t;
        clr  = c;
        @(negedge clk);
        tick = 1'b0;
        clr  = 1'b0;
        if (early === 1'b1) early_n++;
        if (late === 1'b1) late_n++;
    endtask

    // Tick arrives n cycles after the previous one.
    task automatic gap(input int n);
        repeat (n - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_fault", int'(fault), 0);
        check_val("rst_early", int'(early), 0);
        check_val("rst_late", int'(late), 0);
        check_val("rst_period", int'(period), 0);
        check_val("rst_miss", int'(miss_cnt), 0);
        rst = 1'b0;

        // Acquire lock with nominal period.
        gap(7);
        check_val("idle_ref_period", int'(period), 0);
        repeat (3) gap(20);
        check_val("acq_3good_locked", int'(locked), 0);
        gap(20);
        check_val("lock_5th_tick", int'(locked), 1);
        check_val("lock_period", int'(period), 20);
        check_val("lock_miss", int'(miss_cnt), 0);
        check_val("lock_fault", int'(fault), 0);
        check_val("lock_no_pulses", early_n + late_n, 0);

        // Early tick while locked.
        gap(17);
        check_val("early_pulse", int'(early), 1);
        check_val("early_fault", int'(fault), 1);
        check_val("early_locked", int'(locked), 0);
        check_val("early_miss", int'(miss_cnt), 1);
        check_val("early_period", int'(period), 17);
        step(1'b0, 1'b0);
        check_val("early_one_cycle", int'(early), 0);
        check_val("early_count", early_n, 1);

        step(1'b0, 1'b1);
        check_val("clr_fault", int'(fault), 0);
        check_val("clr_miss", int'(miss_cnt), 0);
        gap(5);
        repeat (4) gap(20);
        check_val("relock", int'(locked), 1);

        // Ticks stop while locked: one late pulse at interval 23.
        late_n = 0;
        repeat (22) step(1'b0, 1'b0);
        check_val("pre_timeout_late", late_n, 0);
        check_val("pre_timeout_fault", int'(fault), 0);
        step(1'b0, 1'b0);
        check_val("timeout_late", int'(late), 1);
        check_val("timeout_fault", int'(fault), 1);
        check_val("timeout_locked", int'(locked), 0);
        check_val("timeout_miss", int'(miss_cnt), 1);
        repeat (16) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_val("tick40_late_count", late_n, 1);
        check_val("tick40_period", int'(period), 40);
        check_val("tick40_miss", int'(miss_cnt), 1);
        check_val("tick40_fault", int'(fault), 1);

        // clr and tick together in FAULT: tick ignored.
        step(1'b1, 1'b1);
        check_val("clrtick_fault", int'(fault), 0);
        check_val("clrtick_locked", int'(locked), 0);
        check_val("clrtick_miss", int'(miss_cnt), 0);
        check_val("clrtick_period", int'(period), 40);
        gap(20);
        check_val("clrtick_ref_period", int'(period), 40);
        repeat (3) gap(20);
        check_val("clrtick_acq_locked", int'(locked), 0);
        check_val("clrtick_acq_period", int'(period), 20);
        gap(20);
        check_val("clrtick_lock", int'(locked), 1);

        // Window edges in ACQ, late tick resets the run.
        step(1'b0, 1'b1);
        gap(3);
        gap(20);
        gap(22);
        gap(18);
        check_val("edge_miss", int'(miss_cnt), 0);
        check_val("edge_locked", int'(locked), 0);
        check_val("edge_period", int'(period), 18);
        late_n = 0;
        gap(23);
        check_val("acq_late_count", late_n, 1);
        check_val("acq_late_locked", int'(locked), 0);
        check_val("acq_late_fault", int'(fault), 0);
        check_val("acq_late_miss", int'(miss_cnt), 1);
        check_val("acq_late_period", int'(period), 23);
        gap(17);
        check_val("acq_early_pulse", int'(early), 1);
        check_val("acq_early_fault", int'(fault), 0);
        check_val("acq_early_miss", int'(miss_cnt), 2);
        repeat (3) gap(20);
        check_val("acq_rerun_locked", int'(locked), 0);
        gap(20);
        check_val("acq_rerun_lock", int'(locked), 1);

        // Fault then good ticks: recovery only with the macro.
        gap(17);
        check_val("rec_fault", int'(fault), 1);
        check_val("rec_miss", int'(miss_cnt), 3);
        repeat (4) gap(20);
`ifdef PPC_AUTO_RECOVER_EN
        check_val("rec_locked", int'(locked), 1);
        check_val("rec_fault_clear", int'(fault), 0);
`else
        check_val("sticky_locked", int'(locked), 0);
        check_val("sticky_fault", int'(fault), 1);
`endif
        check_val("rec_miss_after", int'(miss_cnt), 3);

        // rst beats tick.
        rst = 1'b1;
        step(1'b1, 1'b0);
        check_val("rst2_locked", int'(locked), 0);
        check_val("rst2_fault", int'(fault), 0);
        check_val("rst2_period", int'(period), 0);
        check_val("rst2_miss", int'(miss_cnt), 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
